// File: rtl/alu_op_sequencer.sv
// Registered command front-end for the 3-bit ALU: holds operands for SETTLE cycles,
// captures the result into a small FIFO. Optional checker enabled by ALU_SEQ_SELFCHECK_EN.
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_sel,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    output logic [1:0] alu_sel,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    input  logic [5:0] alu_op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [5:0] res_data,
    output logic [1:0] res_sel,
`ifdef ALU_SEQ_SELFCHECK_EN
    output logic       selfchk_err,
    output logic [7:0] selfchk_cnt,
`endif
    output logic [7:0] ops_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_settle;
    logic [1:0]     r_alu_sel;
    logic [2:0]     r_alu_a;
    logic [2:0]     r_alu_b;
    logic [7:0]     r_ops_done;

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [7:0]     r_mem [DEPTH];

    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic           w_has_room;
    logic [7:0]     w_head;

    // Room is checked only at accept; nothing else can push while a command
    // is in flight, so the reserved slot is guaranteed at capture time.
    assign w_has_room = (r_count < CW'(DEPTH));
    assign cmd_ready  = (r_state == ST_IDLE) && w_has_room;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_push     = (r_state == ST_CAPTURE);
    assign w_pop      = res_ready && (r_count != '0);

    assign alu_sel  = r_alu_sel;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign ops_done = r_ops_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_settle   <= 4'd0;
            r_alu_sel  <= 2'd0;
            r_alu_a    <= 3'd0;
            r_alu_b    <= 3'd0;
            r_ops_done <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_sel <= cmd_sel;
                        r_alu_a   <= cmd_a;
                        r_alu_b   <= cmd_b;
                        r_settle  <= 4'(SETTLE);
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_settle <= 4'd1) begin
                        r_settle <= 4'd0;
                        r_state  <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (r_ops_done != 8'hFF) begin
                        r_ops_done <= r_ops_done + 8'd1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result storage: entry is {opcode, result}; no reset needed on the array.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_alu_sel, alu_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign res_valid = (r_count != '0);
    assign res_data  = w_head[5:0];
    assign res_sel   = w_head[7:6];

`ifdef ALU_SEQ_SELFCHECK_EN
    logic       r_selfchk_err;
    logic [7:0] r_selfchk_cnt;
    logic [5:0] w_expect;

    // Reference result built from the held operands, per the ALU's documented contract.
    always_comb begin
        w_expect = 6'd0;
        case (r_alu_sel)
            2'b00:   w_expect = {3'b000, r_alu_a & r_alu_b};
            2'b01:   w_expect = {3'b000, r_alu_a} * {3'b000, r_alu_b};
            2'b10:   w_expect = {3'b000, ~(r_alu_a & r_alu_b)};
            default: w_expect = {3'b000, r_alu_a ^ r_alu_b};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_selfchk_err <= 1'b0;
            r_selfchk_cnt <= 8'd0;
        end else if (w_push && (alu_op != w_expect)) begin
            r_selfchk_err <= 1'b1;
            if (r_selfchk_cnt != 8'hFF) begin
                r_selfchk_cnt <= r_selfchk_cnt + 8'd1;
            end
        end
    end

    assign selfchk_err = r_selfchk_err;
    assign selfchk_cnt = r_selfchk_cnt;
`endif

endmodule
